// File: rtl/sipo_rx_if.sv
// Serial-in / parallel-out receive bundle: bit stream in, handshaked parallel word out.
// The slave side is the deserializer; the master side is the bit source plus word consumer.
interface sipo_rx_if #(
    parameter int WIDTH = 4
);
    localparam int CW = $clog2(WIDTH);

    logic             serial_in;
    logic             bit_valid;
    logic             sync;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             overrun;
    logic [CW-1:0]    bit_cnt;

    modport slave (
        input  serial_in,
        input  bit_valid,
        input  sync,
        input  out_ready,
        output out_data,
        output out_valid,
        output overrun,
        output bit_cnt
    );

    modport master (
        output serial_in,
        output bit_valid,
        output sync,
        output out_ready,
        input  out_data,
        input  out_valid,
        input  overrun,
        input  bit_cnt
    );
endinterface

// File: rtl/sipo_rx.sv
// Purpose: assemble qualified serial bits into WIDTH-bit words, MSB- or LSB-first.
// Latency: out_valid/out_data update on the same edge that samples the final bit of a word.
// Backpressure: a word completing while out_valid=1 and out_ready=0 is dropped and flags sticky overrun.
module sipo_rx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic     clk,
    input  logic     rst,
    sipo_rx_if.slave rx
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    logic [WIDTH-1:0] shreg_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             ovr_q;

    logic take_bit;
    logic word_done;
    logic load;
    logic drop;
    logic drain;

    // Shift register with the current bit already folded in; on the final bit this is the full word.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign word = {shreg_q[WIDTH-2:0], rx.serial_in};
        end else begin : g_lsb_first
            assign word = {rx.serial_in, shreg_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        take_bit  = rx.bit_valid && !rx.sync;
        word_done = take_bit && (cnt_q == LAST_IDX);
        load      = word_done && (!valid_q || rx.out_ready);
        drop      = word_done && valid_q && !rx.out_ready;
        drain     = valid_q && rx.out_ready && !word_done;
    end

    // Accumulator: sync discards the partial word and ignores the bit presented with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else if (rx.sync) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else if (rx.bit_valid) begin
            if (word_done) begin
                shreg_q <= '0;
                cnt_q   <= '0;
            end else begin
                shreg_q <= word;
                cnt_q   <= cnt_q + CW'(1);
            end
        end
    end

    // Output holding register; a completing word may replace a word being consumed this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            if (load) begin
                data_q  <= word;
                valid_q <= 1'b1;
            end else if (drain) begin
                valid_q <= 1'b0;
            end
            if (drop) begin
                ovr_q <= 1'b1;
            end
        end
    end

    assign rx.out_data  = data_q;
    assign rx.out_valid = valid_q;
    assign rx.overrun   = ovr_q;
    assign rx.bit_cnt   = cnt_q;

    a_hold_while_stalled: assert property (
        @(posedge clk) disable iff (rst)
        (rx.out_valid && !rx.out_ready) |=> (rx.out_valid && $stable(rx.out_data))
    );

    a_overrun_sticky: assert property (
        @(posedge clk) disable iff (rst)
        rx.overrun |=> rx.overrun
    );
endmodule

// File: tb/tb_sipo_rx.sv
// Bench for sipo_rx: MSB-first and LSB-first instances driven with identical stimulus,
// checked against an arrival-order bit model and a 4-bit MSB-first serializer.
module tb_sipo_rx;
    logic clk;
    logic rst;

    int errors = 0;
    int checks = 0;

    sipo_rx_if #(.WIDTH(4)) if_m ();
    sipo_rx_if #(.WIDTH(4)) if_l ();

    sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst(rst), .rx(if_m));
    sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst(rst), .rx(if_l));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: bits kept in arrival order; a word is assembled only when four have arrived.
    int         m_cnt;
    bit         m_bits[4];
    bit         m_valid;
    bit         m_ovr;
    logic [3:0] m_dm;
    logic [3:0] m_dl;

    task automatic cyc(input logic bv, input logic s, input logic sy, input logic rdy, input logic r);
        bit         done;
        logic [3:0] wm;
        logic [3:0] wl;
        if_m.bit_valid = bv;  if_l.bit_valid = bv;
        if_m.serial_in = s;   if_l.serial_in = s;
        if_m.sync      = sy;  if_l.sync      = sy;
        if_m.out_ready = rdy; if_l.out_ready = rdy;
        rst = r;
        done = 1'b0;
        wm = '0;
        wl = '0;
        if (r) begin
            m_cnt = 0; m_valid = 0; m_ovr = 0; m_dm = '0; m_dl = '0;
        end else begin
            if (sy) begin
                m_cnt = 0;
            end else if (bv) begin
                m_bits[m_cnt] = s;
                m_cnt++;
                if (m_cnt == 4) begin
                    done  = 1'b1;
                    m_cnt = 0;
                    for (int i = 0; i < 4; i++) begin
                        wm[3-i] = m_bits[i];
                        wl[i]   = m_bits[i];
                    end
                end
            end
            if (done) begin
                if (!m_valid || rdy) begin
                    m_valid = 1; m_dm = wm; m_dl = wl;
                end else begin
                    m_ovr = 1;
                end
            end else if (m_valid && rdy) begin
                m_valid = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Sends n bits taken from seq[3] downward; out_ready is rdy_last only on the final bit.
    task automatic send_seq(input logic [3:0] seq, input int n, input logic rdy_last);
        for (int i = 0; i < n; i++)
            cyc(1'b1, seq[3-i], 1'b0, (i == n-1) ? rdy_last : 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        checks++;
        if (if_m.out_data !== 4'h0 || if_l.out_data !== 4'h0) begin
            errors++; $display("FAIL reset_data: got %h/%h expected 0/0", if_m.out_data, if_l.out_data);
        end
        checks++;
        if (if_m.out_valid !== 1'b0 || if_m.overrun !== 1'b0 || if_m.bit_cnt !== 2'd0) begin
            errors++; $display("FAIL reset_flags: got v=%b o=%b c=%0d expected 0 0 0",
                               if_m.out_valid, if_m.overrun, if_m.bit_cnt);
        end
        checks++;
        if (if_l.out_valid !== 1'b0 || if_l.overrun !== 1'b0 || if_l.bit_cnt !== 2'd0) begin
            errors++; $display("FAIL reset_flags_lsb: got v=%b o=%b c=%0d expected 0 0 0",
                               if_l.out_valid, if_l.overrun, if_l.bit_cnt);
        end
    endtask

    task automatic test_basic_order();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send_seq(4'b1011, 3, 1'b0);
        checks++;
        if (if_m.out_valid !== 1'b0 || if_m.bit_cnt !== 2'd3) begin
            errors++; $display("FAIL partial_word: got v=%b c=%0d expected v=0 c=3", if_m.out_valid, if_m.bit_cnt);
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (if_m.out_data !== 4'b1011 || if_m.out_valid !== 1'b1 || if_m.bit_cnt !== 2'd0) begin
            errors++; $display("FAIL msb_first: got d=%b v=%b c=%0d expected 1011 1 0",
                               if_m.out_data, if_m.out_valid, if_m.bit_cnt);
        end
        checks++;
        if (if_l.out_data !== 4'b1101 || if_l.out_valid !== 1'b1) begin
            errors++; $display("FAIL lsb_first: got d=%b v=%b expected 1101 1", if_l.out_data, if_l.out_valid);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (if_m.out_valid !== 1'b0 || if_m.out_data !== 4'b1011) begin
            errors++; $display("FAIL consume_retain: got v=%b d=%b expected 0 1011", if_m.out_valid, if_m.out_data);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (if_m.out_valid !== 1'b0 || if_l.out_valid !== 1'b0) begin
            errors++; $display("FAIL ready_idle: got v=%b/%b expected 0/0", if_m.out_valid, if_l.out_valid);
        end
    endtask

    task automatic test_gaps();
        logic [3:0] seq;
        seq = 4'b1100;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, seq[3-i], 1'b0, 1'b0, 1'b0);
            if (i < 3) begin
                for (int g = 0; g < 3; g++) cyc(1'b0, ~seq[3-i], 1'b0, 1'b0, 1'b0);
                checks++;
                if (if_m.bit_cnt !== 2'(i + 1)) begin
                    errors++; $display("FAIL gap_hold: got c=%0d expected %0d", if_m.bit_cnt, i + 1);
                end
            end
        end
        checks++;
        if (if_m.out_data !== 4'b1100 || if_l.out_data !== 4'b0011 || if_m.out_valid !== 1'b1) begin
            errors++; $display("FAIL gap_word: got %b/%b v=%b expected 1100/0011 1",
                               if_m.out_data, if_l.out_data, if_m.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send_seq(4'b1010, 4, 1'b0);
        send_seq(4'b0101, 4, 1'b0);
        checks++;
        if (if_m.out_data !== 4'b1010 || if_m.out_valid !== 1'b1 || if_m.overrun !== 1'b1) begin
            errors++; $display("FAIL overrun_drop: got d=%b v=%b o=%b expected 1010 1 1",
                               if_m.out_data, if_m.out_valid, if_m.overrun);
        end
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (if_m.overrun !== 1'b1 || if_l.overrun !== 1'b1) begin
            errors++; $display("FAIL overrun_sticky: got %b/%b expected 1/1", if_m.overrun, if_l.overrun);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send_seq(4'b1010, 4, 1'b0);
        send_seq(4'b0101, 4, 1'b1);
        checks++;
        if (if_m.out_data !== 4'b0101 || if_m.out_valid !== 1'b1 || if_m.overrun !== 1'b0) begin
            errors++; $display("FAIL handoff: got d=%b v=%b o=%b expected 0101 1 0",
                               if_m.out_data, if_m.out_valid, if_m.overrun);
        end
        checks++;
        if (if_l.out_data !== 4'b1010) begin
            errors++; $display("FAIL handoff_lsb: got d=%b expected 1010", if_l.out_data);
        end
    endtask

    task automatic test_sync();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send_seq(4'b1100, 2, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (if_m.bit_cnt !== 2'd0 || if_m.out_valid !== 1'b0) begin
            errors++; $display("FAIL sync_clear: got c=%0d v=%b expected 0 0", if_m.bit_cnt, if_m.out_valid);
        end
        send_seq(4'b0110, 4, 1'b0);
        checks++;
        if (if_m.out_data !== 4'b0110 || if_l.out_data !== 4'b0110 || if_m.out_valid !== 1'b1) begin
            errors++; $display("FAIL sync_word: got %b/%b v=%b expected 0110/0110 1",
                               if_m.out_data, if_l.out_data, if_m.out_valid);
        end
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (if_m.out_data !== 4'b0110 || if_m.out_valid !== 1'b1 || if_m.overrun !== 1'b0) begin
            errors++; $display("FAIL sync_outputs: got d=%b v=%b o=%b expected 0110 1 0",
                               if_m.out_data, if_m.out_valid, if_m.overrun);
        end
    endtask

    task automatic test_reset_midword();
        send_seq(4'b1000, 3, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (if_m.out_data !== 4'h0 || if_m.out_valid !== 1'b0 || if_m.overrun !== 1'b0 || if_m.bit_cnt !== 2'd0) begin
            errors++; $display("FAIL reset_midword: got d=%b v=%b o=%b c=%0d expected 0000 0 0 0",
                               if_m.out_data, if_m.out_valid, if_m.overrun, if_m.bit_cnt);
        end
        send_seq(4'b1111, 4, 1'b0);
        checks++;
        if (if_m.out_data !== 4'b1111 || if_l.out_data !== 4'b1111 || if_m.out_valid !== 1'b1) begin
            errors++; $display("FAIL after_reset_word: got %b/%b v=%b expected 1111/1111 1",
                               if_m.out_data, if_l.out_data, if_m.out_valid);
        end
    endtask

    // Each value is serialized by a 4-bit parallel-in serial-out shifter, MSB first.
    task automatic test_all_values();
        logic [3:0] piso;
        logic [3:0] rev;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int v = 0; v < 16; v++) begin
            piso = 4'(v);
            for (int b = 0; b < 4; b++) begin
                cyc(1'b1, piso[3], 1'b0, 1'b1, 1'b0);
                piso = {piso[2:0], 1'b0};
            end
            for (int b = 0; b < 4; b++) rev[b] = 1'(v >> (3 - b));
            checks++;
            if (if_m.out_data !== 4'(v) || if_m.out_valid !== 1'b1) begin
                errors++; $display("FAIL value_msb: got d=%h v=%b expected %h 1", if_m.out_data, if_m.out_valid, v);
            end
            checks++;
            if (if_l.out_data !== rev) begin
                errors++; $display("FAIL value_lsb: got d=%h expected %h", if_l.out_data, rev);
            end
        end
    endtask

    task automatic test_random();
        logic bv, s, sy, rdy, r;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 400; n++) begin
            bv  = ($urandom_range(0, 9) < 7);
            s   = 1'($urandom);
            sy  = ($urandom_range(0, 19) == 0);
            rdy = 1'($urandom);
            r   = ($urandom_range(0, 99) == 0);
            cyc(bv, s, sy, rdy, r);
            checks++;
            if (if_m.out_data !== m_dm || if_l.out_data !== m_dl) begin
                errors++; $display("FAIL rand_data @%0d: got %h/%h expected %h/%h", n, if_m.out_data, if_l.out_data, m_dm, m_dl);
            end
            checks++;
            if (if_m.out_valid !== m_valid || if_l.out_valid !== m_valid) begin
                errors++; $display("FAIL rand_valid @%0d: got %b/%b expected %b", n, if_m.out_valid, if_l.out_valid, m_valid);
            end
            checks++;
            if (if_m.overrun !== m_ovr || if_l.overrun !== m_ovr) begin
                errors++; $display("FAIL rand_overrun @%0d: got %b/%b expected %b", n, if_m.overrun, if_l.overrun, m_ovr);
            end
            checks++;
            if (if_m.bit_cnt !== 2'(m_cnt) || if_l.bit_cnt !== 2'(m_cnt)) begin
                errors++; $display("FAIL rand_cnt @%0d: got %0d/%0d expected %0d", n, if_m.bit_cnt, if_l.bit_cnt, m_cnt);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        if_m.serial_in = 1'b0; if_l.serial_in = 1'b0;
        if_m.bit_valid = 1'b0; if_l.bit_valid = 1'b0;
        if_m.sync      = 1'b0; if_l.sync      = 1'b0;
        if_m.out_ready = 1'b0; if_l.out_ready = 1'b0;
        m_cnt = 0; m_valid = 0; m_ovr = 0; m_dm = '0; m_dl = '0;
        test_reset();
        test_basic_order();
        test_gaps();
        test_back_to_back();
        test_sync();
        test_reset_midword();
        test_all_values();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
